// File: rtl/mul_rr_sequencer.sv
// mul_rr_sequencer: two-requester round-robin front end for a shift-add multiplier (optional MUL_EARLY_TERM_EN)
module mul_rr_sequencer #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [M-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [M-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [M+N-1:0] rsp_c,
  output logic           busy
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state;
  logic [M+N-1:0] a_reg, acc, sum;
  logic [N-1:0]   b_reg;
  logic [CW-1:0]  cnt;
  logic           last_grant, g1, done_now;
  // round-robin grant, partial-product accumulation and finish detection
  always_comb begin
    g1 = req1_valid && (!req0_valid || !last_grant);
    req0_ready = state == IDLE && req0_valid && !g1;
    req1_ready = state == IDLE && g1;
    sum = acc + (b_reg[cnt] ? a_reg << cnt : '0);
`ifdef MUL_EARLY_TERM_EN
    done_now = cnt == CW'(N - 1) || ((b_reg >> cnt) >> 1) == '0;
`else
    done_now = cnt == CW'(N - 1);
`endif
  end
  assign busy = state != IDLE;
  // accept one job, iterate one multiplier bit per clock, hold the product until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_c      <= '0;
      cnt        <= '0;
      acc        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          a_reg      <= {{N{1'b0}}, g1 ? req1_a : req0_a};
          b_reg      <= g1 ? req1_b : req0_b;
          acc        <= '0;
          cnt        <= '0;
          rsp_id     <= g1;
          last_grant <= g1;
          state      <= BUSY;
        end
        BUSY: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (done_now) begin
            rsp_c     <= sum;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_rr_sequencer.sv
// tb_mul_rr_sequencer: directed self-checking bench for mul_rr_sequencer
module tb_mul_rr_sequencer;
  logic        clk = 0, rst = 1;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [7:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [15:0] rsp_c;
  int          checks = 0, errors = 0;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_rr_sequencer #(.M(8), .N(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input logic [7:0] b);
    int h = 0;
    for (int i = 0; i < 8; i++) if (b[i]) h = i;
    return EARLY ? h + 1 : 8;
  endfunction

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic do_job(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b);
    int n;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1; end
    else begin req0_a = a; req0_b = b; req0_valid = 1; end
    #1;
    chk({tag, "_rdy"}, id ? req1_ready : req0_ready, 1);
    chk({tag, "_other_rdy"}, id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 0;
    req1_valid = 0;
    chk({tag, "_busy"}, busy, 1);
    wait_rsp(n);
    chk({tag, "_lat"}, n, lat(b));
    chk({tag, "_c"}, rsp_c, a * b);
    chk({tag, "_id"}, rsp_id, id);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, "_done_valid"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    tick();
    tick();
    rst = 0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c", rsp_c, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_rdy0", req0_ready, 0);
    do_job("t1", 0, 8'd13, 8'd11);
    chk("t1_value", rsp_c, 16'd143);
    // max operands, consumer stalls five cycles
    req1_a = 8'hFF; req1_b = 8'hFF; req1_valid = 1;
    #1;
    chk("t2_rdy1", req1_ready, 1);
    chk("t2_rdy0", req0_ready, 0);
    tick();
    req1_valid = 0;
    wait_rsp(n);
    chk("t2_lat", n, lat(8'hFF));
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_c", rsp_c, 16'hFE01);
      chk("t2_hold_id", rsp_id, 1);
      chk("t2_hold_busy", busy, 1);
      chk("t2_hold_valid", rsp_valid, 1);
      chk("t2_hold_rdy", {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t2_idle_valid", rsp_valid, 0);
    chk("t2_idle_busy", busy, 0);
    // both requesters continuously valid: strict alternation
    req0_a = 3; req0_b = 4; req1_a = 5; req1_b = 6;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(n);
      chk("t3_valid", rsp_valid, 1);
      chk("t3_id", rsp_id, k % 2);
      chk("t3_c", rsp_c, (k % 2) ? 30 : 12);
      tick();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    tick();
    chk("t3_idle", busy, 0);
    // reset during the fourth BUSY cycle drops the job
    req0_a = 9; req0_b = 7; req0_valid = 1;
    tick();
    req0_valid = 0;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t4_valid", rsp_valid, 0);
    chk("t4_busy", busy, 0);
    for (int k = 0; k < 10; k++) tick();
    chk("t4_no_rsp", rsp_valid, 0);
    do_job("t4b", 1, 8'd9, 8'd7);
    chk("t4b_value", rsp_c, 16'd63);
    // zero multiplier and sparse multiplier
    do_job("t5a", 0, 8'd200, 8'd0);
    do_job("t5b", 1, 8'd200, 8'h05);
    chk("t5b_value", rsp_c, 16'd1000);
    // operand changes after acceptance are ignored
    req0_a = 6; req0_b = 7; req0_valid = 1;
    tick();
    req0_valid = 0;
    req0_a = 1; req0_b = 1;
    wait_rsp(n);
    chk("t6_lat", n, lat(8'd7));
    chk("t6_c", rsp_c, 16'd42);
    chk("t6_id", rsp_id, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
